// File: rtl/bcd_scan_ctrl_if.sv
// CPU peripheral-bus view of the display scanner: address, write data/strobe and combinational readback.
interface bcd_scan_ctrl_if;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemWrite;
  logic [31:0] Read_data;

  modport master (output Address, output Write_data, output MemWrite, input Read_data);
  modport slave  (input Address, input Write_data, input MemWrite, output Read_data);
endinterface

// File: rtl/bcd_scan_ctrl.sv
// 4-digit 7-seg scanner with frame shadow; leds/ans registered one cycle after state, bus writes never stall.
// Optional legacy raw passthrough (ctrl bit5) is built only when BCD_RAW_PASSTHRU_EN is defined.
module bcd_scan_ctrl #(
  parameter int          SCAN_DIV  = 100000,
  parameter int          BLANK_CYC = 1000,
  parameter logic [31:0] DATA_ADDR = 32'h40000010,
  parameter logic [31:0] CTRL_ADDR = 32'h40000014
) (
  input  logic               clk,
  input  logic               reset,
  bcd_scan_ctrl_if.slave     bus,
  output logic [6:0]         leds,
  output logic [3:0]         ans
);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

`ifdef BCD_RAW_PASSTHRU_EN
  localparam logic [5:0] CTRL_WMASK = 6'h3F;
`else
  localparam logic [5:0] CTRL_WMASK = 6'h1F;
`endif

  state_t      state, state_n;
  logic [15:0] data, shadow;
  logic [5:0]  ctrl;
  logic [1:0]  idx, idx_n;
  logic [31:0] cnt, cnt_n;
  logic        shadow_ld;
  logic [6:0]  leds_n;
  logic [3:0]  ans_n;
  logic        en, raw;
  logic [3:0]  mask, digit;
  logic        unused_wdat;

  assign en          = ctrl[0];
  assign mask        = ctrl[4:1];
  assign raw         = ctrl[5];
  assign digit       = shadow[{idx, 2'b00} +: 4];
  assign unused_wdat = ^bus.Write_data[31:16];

  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    bus.Read_data = 32'h0;
    if (bus.Address == DATA_ADDR)      bus.Read_data = {16'h0, data};
    else if (bus.Address == CTRL_ADDR) bus.Read_data = {26'h0, ctrl};
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 32'd1;
    idx_n     = idx;
    shadow_ld = 1'b0;
    leds_n    = 7'h7F;
    ans_n     = 4'hF;
    case (state)
      IDLE: begin
        cnt_n = 32'd0;
        if (en) begin
          state_n   = SHOW;
          idx_n     = 2'd0;
          shadow_ld = 1'b1;
        end
      end
      SHOW: begin
        // Masked digits keep their slot, only the anode stays off.
        leds_n = seg7(digit);
        ans_n  = ~({3'b000, mask[idx]} << idx);
        if (cnt == 32'(SCAN_DIV - 1)) begin
          state_n = BLANK;
          cnt_n   = 32'd0;
        end
      end
      BLANK: begin
        if (cnt == 32'(BLANK_CYC - 1)) begin
          state_n   = SHOW;
          cnt_n     = 32'd0;
          idx_n     = idx + 2'd1;
          shadow_ld = (idx == 2'd3);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 32'd0;
      end
    endcase
    // Disable (or raw mode) overrides the scan immediately, outputs included.
    if (!en || raw) begin
      state_n   = IDLE;
      cnt_n     = 32'd0;
      idx_n     = 2'd0;
      shadow_ld = 1'b0;
      leds_n    = 7'h7F;
      ans_n     = 4'hF;
    end
`ifdef BCD_RAW_PASSTHRU_EN
    if (raw) begin
      leds_n = data[6:0];
      ans_n  = data[11:8];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data   <= 16'h0;
      ctrl   <= 6'h0;
      shadow <= 16'h0;
      idx    <= 2'd0;
      cnt    <= 32'd0;
      state  <= IDLE;
      leds   <= 7'h7F;
      ans    <= 4'hF;
    end else begin
      if (bus.MemWrite && bus.Address == DATA_ADDR) data <= bus.Write_data[15:0];
      if (bus.MemWrite && bus.Address == CTRL_ADDR) ctrl <= bus.Write_data[5:0] & CTRL_WMASK;
      // Shadow samples pre-write data when a write lands on a frame boundary.
      if (shadow_ld) shadow <= data;
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      leds  <= leds_n;
      ans   <= ans_n;
    end
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl with SCAN_DIV=4, BLANK_CYC=2 (24-cycle frames).
module tb_bcd_scan_ctrl;
  localparam logic [31:0] DATA_A = 32'h40000010;
  localparam logic [31:0] CTRL_A = 32'h40000014;
  localparam logic [3:0]  AD = 4'b1111;
  localparam logic [6:0]  LD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] leds;
  logic [3:0] ans;
  int checks = 0;
  int failures = 0;
  int n = 0;

  bcd_scan_ctrl_if bus();

  bcd_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(2)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .leds(leds), .ans(ans)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  ans;
    logic [6:0]  leds;
  } vec_t;
  vec_t vt[$];

  task automatic add(input int c, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] ea, input logic [6:0] el);
    vec_t v;
    v.cyc = c; v.wr = w; v.addr = a; v.wdat = d; v.ans = ea; v.leds = el;
    vt.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    #1;
    bus.MemWrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Address = a;
    bus.Write_data = d;
    bus.MemWrite = 1'b1;
    tick();
  endtask

  task automatic chk_out(input string name, input logic [3:0] ea, input logic [6:0] el);
    checks++;
    if (ans !== ea || leds !== el) begin
      failures++;
      $display("FAIL %s: ans=%b leds=%b, expected ans=%b leds=%b", name, ans, leds, ea, el);
    end
  endtask

  task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.Address = a;
    #1;
    checks++;
    if (bus.Read_data !== exp) begin
      failures++;
      $display("FAIL %s: Read_data=%h, expected %h", name, bus.Read_data, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    // n counts edges from the enabling ctrl write (edge 0); digit slots start at n=2 and repeat every 6.
    add(0,   1, CTRL_A, 32'h1F, AD, LD);
    add(1,   0, 0, 0, AD, LD);
    add(2,   0, 0, 0, 4'b1110, 7'b0001110);
    add(5,   0, 0, 0, 4'b1110, 7'b0001110);
    add(6,   0, 0, 0, AD, LD);
    add(7,   0, 0, 0, AD, LD);
    add(8,   0, 0, 0, 4'b1101, 7'b0001000);
    add(11,  0, 0, 0, 4'b1101, 7'b0001000);
    add(12,  0, 0, 0, AD, LD);
    add(14,  0, 0, 0, 4'b1011, 7'b0100100);
    add(17,  0, 0, 0, 4'b1011, 7'b0100100);
    add(18,  0, 0, 0, AD, LD);
    add(20,  0, 0, 0, 4'b0111, 7'b1111001);
    add(23,  0, 0, 0, 4'b0111, 7'b1111001);
    add(24,  0, 0, 0, AD, LD);
    add(26,  0, 0, 0, 4'b1110, 7'b0001110);
    add(32,  1, DATA_A, 32'h8888, 4'b1101, 7'b0001000);
    add(38,  0, 0, 0, 4'b1011, 7'b0100100);
    add(44,  0, 0, 0, 4'b0111, 7'b1111001);
    add(50,  0, 0, 0, 4'b1110, 7'b0000000);
    add(56,  0, 0, 0, 4'b1101, 7'b0000000);
    add(60,  1, CTRL_A, 32'h0B, AD, LD);
    add(62,  0, 0, 0, 4'b1011, 7'b0000000);
    add(68,  0, 0, 0, 4'b1111, 7'b0000000);
    add(74,  0, 0, 0, 4'b1110, 7'b0000000);
    add(80,  0, 0, 0, 4'b1111, 7'b0000000);
    add(86,  0, 0, 0, 4'b1011, 7'b0000000);
    add(87,  1, CTRL_A, 32'h0A, 4'b1011, 7'b0000000);
    add(88,  0, 0, 0, AD, LD);
    add(90,  1, DATA_A, 32'h0003, AD, LD);
    add(92,  1, CTRL_A, 32'h0B, AD, LD);
    add(93,  0, 0, 0, AD, LD);
    add(94,  0, 0, 0, 4'b1110, 7'b0110000);
    add(97,  0, 0, 0, 4'b1110, 7'b0110000);
    add(98,  0, 0, 0, AD, LD);
    add(100, 0, 0, 0, 4'b1111, 7'b1000000);

    bus.Address = 32'h0;
    bus.Write_data = 32'h0;
    bus.MemWrite = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk_out("reset_out", AD, LD);
    chk_rd("reset_data", DATA_A, 32'h0);
    chk_rd("reset_ctrl", CTRL_A, 32'h0);

    wr(32'h40000018, 32'h3F);
    @(negedge clk);
    chk_rd("unmapped_ctrl", CTRL_A, 32'h0);
    chk_rd("unmapped_read", 32'h40000018, 32'h0);
    tick();
    @(negedge clk);
    chk_out("unmapped_out", AD, LD);

    wr(DATA_A, 32'h12AF);
    @(negedge clk);
    chk_rd("data_rb", DATA_A, 32'h12AF);

    n = -1;
    foreach (vt[i]) begin
      while (n < vt[i].cyc - 1) tick();
      if (vt[i].wr) wr(vt[i].addr, vt[i].wdat);
      else tick();
      @(negedge clk);
      chk_out($sformatf("vec%0d_n%0d", i, vt[i].cyc), vt[i].ans, vt[i].leds);
    end

    // Reset pulse while the digit-1 blank is in progress.
    while (n < 103) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_out($sformatf("post_reset_n%0d", n), AD, LD);
      tick();
    end
    @(negedge clk);
    chk_rd("post_reset_data", DATA_A, 32'h0);
    chk_rd("post_reset_ctrl", CTRL_A, 32'h0);

    wr(DATA_A, 32'h0E40);
    wr(CTRL_A, 32'h21);
`ifdef BCD_RAW_PASSTHRU_EN
    @(negedge clk);
    chk_rd("raw_ctrl", CTRL_A, 32'h21);
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      chk_out($sformatf("raw_static%0d", k), 4'b1110, 7'b1000000);
    end
`else
    @(negedge clk);
    chk_rd("noraw_ctrl", CTRL_A, 32'h01);
    chk_rd("noraw_data", DATA_A, 32'h0E40);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
